mult_scheduler: RTL
===================

Name: mult_scheduler

Overview:
- Owns the single shared iterative multiplier of the dual-issue pipeline and arbitrates it between execute slot 1 (older) and slot 2 (younger).
- Sequences each MULT/MULTU: operand capture, iteration, sign fix-up, HI/LO write.
- Drives the per-slot execute-stall inputs (mult_stallE1/E2) consumed by the hazard detector.
- Sits in the E stage beside the ALUs; HI/LO register file is the write target.

Parameters:
- BITS_PER_CYCLE, 2, multiplier bits retired per iteration; 32 % BITS_PER_CYCLE must be 0.
- ITERS, 32/BITS_PER_CYCLE, derived iteration count N (localparam).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req1, req2  in  1  slot issues MULT/MULTU in E this cycle; held while its stall is high.
- signed1, signed2  in  1  1 = MULT (two's complement), 0 = MULTU.
- a1, b1, a2, b2  in  32  operands (rs, rt).
- flush1, flush2  in  1  slot's E-stage instruction is killed.
- mult_stall1, mult_stall2  out  1  to hazard detector as mult_stallE1/E2.
- hilo_we  out  1  one-cycle HI/LO write strobe.
- hi, lo  out  32  product upper/lower word; valid when hilo_we = 1.
- done1, done2  out  1  completion pulse identifying the slot.
- busy  out  1  unit occupied; D-stage MFHI/MFLO stall on it.

Behaviour:
- Async reset → IDLE, owner = 0, count = 0; all outputs 0, hi/lo = 0.
- States: IDLE, RUN, DONE. Registers: owner (1/2), count, product, neg flag.
- IDLE:
  - req1 (no flush1) wins → RUN, owner = 1. Otherwise req2 (no flush2) → RUN, owner = 2.
  - Capture |a|, |b| (abs only when signed) and neg = signed & (a[31] ^ b[31]); count = N.
- RUN: one core iteration per cycle, count decrements; at count == 1 → DONE.
- DONE:
  - Product final (negated when neg); hilo_we = 1, hi/lo driven, done<owner> = 1.
  - Leave to RUN if the other slot's req is pending (no flush), else IDLE.
  - The finishing slot's req in this cycle is the same instruction and is ignored.
- Stall generation (combinational):
  - mult_stallX = reqX & ~(state == DONE & owner == X).
  - So the requester stalls in its request cycle and through all N RUN cycles, and releases in DONE.
  - Latency from first req to hilo_we is N+1 cycles.
- Arbitration: fixed priority, slot 1 over slot 2 in IDLE and DONE.
  - A request arriving while the other slot owns the unit waits with its stall high.
- Flush:
  - flush of the owner in RUN → IDLE next cycle, no write.
  - flush of the owner in DONE suppresses hilo_we and done.
  - flush of a waiting slot drops its pending request.
  - flushX forces mult_stallX = 0.
- busy = (state != IDLE).
- Unsigned and signed products are both 64-bit exact. Signed −2^31 × −2^31 = 0x4000_0000_0000_0000.

Optional Feature:
- Macro MULT_EARLY_OUT_EN.
- Defined: in RUN, if the remaining unshifted multiplier bits are all zero, go to DONE next cycle. Result is identical; latency ≥ 2 cycles.
- Undefined: always exactly N RUN cycles.

Decomposition:
- Package mult_pkg:
  - state enum {IDLE, RUN, DONE}
  - owner encoding
  - ITERS computation
  - 64-bit product typedef
- Sub-module iter_mult_core:
  - unsigned shift-add datapath: load, step, zero_rest (for early-out), product.
  - Scheduler keeps FSM, arbitration, sign handling.

Test Plan:
- req1, signed1 = 1, a1 = −3, b1 = 7 (default N = 16) → mult_stall1 high 17 cycles; DONE cycle: hilo_we = 1, {hi,lo} = 0xFFFFFFFF_FFFFFFEB, done1 = 1.
- req1 & req2 same cycle (MULTU 0xFFFFFFFF×2, MULT 5×−5) → slot 1 first, hi/lo = 0x1 / 0xFFFFFFFE. Slot 2 enters RUN directly from DONE, mult_stall2 continuously high, then hi/lo = 0xFFFFFFFF / 0xFFFFFFE7.
- flush1 on RUN cycle 5 → IDLE next cycle, no hilo_we, mult_stall1 = 0, busy = 0.
- reset_n low mid-RUN → immediately IDLE, all outputs 0. After release, a new req2 completes normally.
- MULT 0x80000000 × 0x80000000 → hi = 0x40000000, lo = 0.
- MULT_EARLY_OUT_EN: MULTU 3×5 → hilo_we within 3 cycles of req, lo = 15. Without the macro, exactly 17 cycles.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and constants for the shared iterative multiplier and its scheduler.
package mult_pkg;

  localparam int unsigned WORD_W             = 32;
  localparam int unsigned PROD_W             = 64;
  localparam int unsigned BITS_PER_CYCLE_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_S1   = 2'd1,
    OWN_S2   = 2'd2
  } owner_e;

  typedef logic [PROD_W-1:0] prod_t;

  // Iteration count N for a given number of multiplier bits retired per cycle
  function automatic int unsigned iters(input int unsigned bpc);
    return WORD_W / bpc;
  endfunction

endpackage

// File: rtl/iter_mult_core.sv
// Unsigned shift-add multiplier datapath retiring BITS_PER_CYCLE multiplier bits per step.
// zero_rest flags that the bits left after the current step are all zero; it is only
// live when MULT_EARLY_OUT_EN is defined and reads 0 otherwise.
module iter_mult_core
  import mult_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = BITS_PER_CYCLE_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              zero_rest,
  output prod_t             product
);

  prod_t             r_acc;
  prod_t             r_mcand;
  logic [WORD_W-1:0] r_mplier;
  prod_t             w_partial;

  // Sum of the shifted multiplicand copies selected by the low multiplier bits
  always_comb begin
    w_partial = '0;
    for (int unsigned k = 0; k < BITS_PER_CYCLE; k++) begin
      if (r_mplier[k]) begin
        w_partial = w_partial + (r_mcand << k);
      end
    end
  end

  // Operand load and one accumulate/shift per step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
    end else if (load) begin
      r_acc    <= '0;
      r_mcand  <= {{(PROD_W-WORD_W){1'b0}}, a};
      r_mplier <= b;
    end else if (step) begin
      r_acc    <= r_acc + w_partial;
      r_mcand  <= r_mcand << BITS_PER_CYCLE;
      r_mplier <= r_mplier >> BITS_PER_CYCLE;
    end
  end

`ifdef MULT_EARLY_OUT_EN
  logic [WORD_W-1:0] w_rest;
  assign w_rest    = r_mplier >> BITS_PER_CYCLE;
  assign zero_rest = (w_rest == '0);
`else
  assign zero_rest = 1'b0;
`endif

  assign product = r_acc;

endmodule

// File: rtl/mult_scheduler.sv
// Shares one iterative multiplier between execute slots 1 (older) and 2 (younger):
// arbitration, sign handling, HI/LO write strobe and per-slot execute stalls.
// Optional early termination is compiled in with MULT_EARLY_OUT_EN.
module mult_scheduler
  import mult_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = BITS_PER_CYCLE_DEF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req1,
  input  logic              req2,
  input  logic              signed1,
  input  logic              signed2,
  input  logic [WORD_W-1:0] a1,
  input  logic [WORD_W-1:0] b1,
  input  logic [WORD_W-1:0] a2,
  input  logic [WORD_W-1:0] b2,
  input  logic              flush1,
  input  logic              flush2,
  output logic              mult_stall1,
  output logic              mult_stall2,
  output logic              hilo_we,
  output logic [WORD_W-1:0] hi,
  output logic [WORD_W-1:0] lo,
  output logic              done1,
  output logic              done2,
  output logic              busy
);

  localparam int unsigned ITERS = iters(BITS_PER_CYCLE);
  localparam int unsigned CNT_W = $clog2(ITERS + 1);

  state_e            r_state, w_state_nxt;
  owner_e            r_owner, w_owner_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_neg, w_neg_nxt;

  logic              w_v1, w_v2;
  logic              w_pick2;
  logic              w_other_pending;
  logic              w_own_flush;
  logic              w_load;
  logic              w_done_st;
  logic              w_sgn;
  logic [WORD_W-1:0] w_a_raw, w_b_raw, w_a_abs, w_b_abs;
  logic              w_neg_new;
  logic              w_zero_rest;
  prod_t             w_core_prod, w_final;

  assign w_v1 = req1 & ~flush1;
  assign w_v2 = req2 & ~flush2;

  // Slot 1 wins when idle; after a completion the other slot gets the unit
  assign w_pick2         = (r_state == ST_DONE) ? (r_owner == OWN_S1) : ~w_v1;
  assign w_other_pending = (r_owner == OWN_S1) ? w_v2 : w_v1;
  assign w_own_flush     = ((r_owner == OWN_S1) & flush1) | ((r_owner == OWN_S2) & flush2);
  assign w_done_st       = (r_state == ST_DONE);

  // Operand select and magnitude extraction for signed requests
  assign w_sgn     = w_pick2 ? signed2 : signed1;
  assign w_a_raw   = w_pick2 ? a2 : a1;
  assign w_b_raw   = w_pick2 ? b2 : b1;
  assign w_a_abs   = (w_sgn & w_a_raw[WORD_W-1]) ? (~w_a_raw + 32'd1) : w_a_raw;
  assign w_b_abs   = (w_sgn & w_b_raw[WORD_W-1]) ? (~w_b_raw + 32'd1) : w_b_raw;
  assign w_neg_new = w_sgn & (w_a_raw[WORD_W-1] ^ w_b_raw[WORD_W-1]);

  // State, owner, iteration count and sign registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_owner <= OWN_NONE;
      r_count <= '0;
      r_neg   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_count <= w_count_nxt;
      r_neg   <= w_neg_nxt;
    end
  end

  // Next-state, arbitration and operand-load decision
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_count_nxt = r_count;
    w_neg_nxt   = r_neg;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_v1 | w_v2) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
          w_owner_nxt = w_pick2 ? OWN_S2 : OWN_S1;
        end
      end
      ST_RUN: begin
        if (w_own_flush) begin
          w_state_nxt = ST_IDLE;
          w_owner_nxt = OWN_NONE;
          w_count_nxt = '0;
        end else if ((r_count == CNT_W'(1)) | w_zero_rest) begin
          w_state_nxt = ST_DONE;
          w_count_nxt = '0;
        end else begin
          w_count_nxt = r_count - CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (w_other_pending) begin
          w_load      = 1'b1;
          w_state_nxt = ST_RUN;
          w_owner_nxt = w_pick2 ? OWN_S2 : OWN_S1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_owner_nxt = OWN_NONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_owner_nxt = OWN_NONE;
        w_count_nxt = '0;
      end
    endcase
    if (w_load) begin
      w_count_nxt = CNT_W'(ITERS);
      w_neg_nxt   = w_neg_new;
    end
  end

  iter_mult_core #(
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (w_load),
    .step      (r_state == ST_RUN),
    .a         (w_a_abs),
    .b         (w_b_abs),
    .zero_rest (w_zero_rest),
    .product   (w_core_prod)
  );

  assign w_final = r_neg ? (~w_core_prod + 64'd1) : w_core_prod;

  // The finishing slot sees its stall drop in DONE; a flushed slot never stalls
  assign mult_stall1 = req1 & ~flush1 & ~(w_done_st & (r_owner == OWN_S1));
  assign mult_stall2 = req2 & ~flush2 & ~(w_done_st & (r_owner == OWN_S2));

  assign hilo_we = w_done_st & ~w_own_flush;
  assign hi      = hilo_we ? w_final[PROD_W-1:WORD_W] : '0;
  assign lo      = hilo_we ? w_final[WORD_W-1:0] : '0;
  assign done1   = hilo_we & (r_owner == OWN_S1);
  assign done2   = hilo_we & (r_owner == OWN_S2);
  assign busy    = (r_state != ST_IDLE);

endmodule
